// File: rtl/router_reg_if.sv
// Router register-block bus: source byte stream, FSM state flags and the
// registered results handed to the destination FIFO.
//   master : drives pkt_valid, data_in, fifo_full and the one-hot FSM flags;
//            observes dout, parity_done, low_pkt_valid, err
//   slave  : the register block (router_reg)
interface router_reg_if;
  localparam int unsigned DATA_W = 8;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_req;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_req,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_req,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// Router register block: latches the header, forwards bytes to the
// destination FIFO, parks a byte while the FIFO is full, accumulates the
// running XOR parity and flags a parity mismatch at packet end.
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : router_reg_if.slave (stream in, FSM flags in, dout/status out)
module router_reg (
  input logic        clk,
  input logic        rst,
  router_reg_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam logic [1:0]  ADDR_INVALID = 2'b11;

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] full_byte;
  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] pkt_parity;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              parity_done_d;
  logic              low_pkt_valid;
  logic              err;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_req;

  assign pkt_valid   = bus.pkt_valid;
  assign data_in     = bus.data_in;
  assign fifo_full   = bus.fifo_full;
  assign detect_addr = bus.detect_addr;
  assign lfd_state   = bus.lfd_state;
  assign ld_state    = bus.ld_state;
  assign laf_state   = bus.laf_state;
  assign full_state  = bus.full_state;
  assign rst_int_req = bus.rst_int_req;

  assign bus.dout          = dout;
  assign bus.parity_done   = parity_done;
  assign bus.low_pkt_valid = low_pkt_valid;
  assign bus.err           = err;

  // Header capture; address 3 is not a valid destination.
  always_ff @(posedge clk) begin
    if (!rst) begin
      header <= '0;
    end else if (detect_addr && pkt_valid && (data_in[1:0] != ADDR_INVALID)) begin
      header <= data_in;
    end
  end

  // Output byte select and the byte parked while the FIFO is full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout      <= '0;
      full_byte <= '0;
    end else begin
      if (lfd_state)                    dout <= header;
      else if (ld_state && !fifo_full)  dout <= data_in;
      else if (laf_state)               dout <= full_byte;

      if (ld_state && fifo_full) full_byte <= data_in;
    end
  end

  // Running parity; a parked byte is folded in when it is captured, so the
  // laf_state replay must not touch the accumulator.
  always_ff @(posedge clk) begin
    if (!rst) begin
      int_parity <= '0;
      pkt_parity <= '0;
    end else begin
      if (detect_addr)                             int_parity <= '0;
      else if (lfd_state)                          int_parity <= int_parity ^ header;
      else if (ld_state && pkt_valid && !full_state) int_parity <= int_parity ^ data_in;

      if (ld_state && !pkt_valid && !fifo_full) pkt_parity <= data_in;
    end
  end

  // Packet-end status; detect_addr clears beat any set condition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_done   <= 1'b0;
      parity_done_d <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
    end else begin
      parity_done_d <= parity_done;

      if (detect_addr)
        parity_done <= 1'b0;
      else if ((ld_state && !fifo_full && !pkt_valid) ||
               (laf_state && low_pkt_valid && !parity_done))
        parity_done <= 1'b1;

      if (rst_int_req)                  low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)  low_pkt_valid <= 1'b1;

      // Compare one cycle after parity_done rises, once pkt_parity has settled.
      if (detect_addr)                         err <= 1'b0;
      else if (parity_done && !parity_done_d)  err <= (int_parity != pkt_parity);
    end
  end
endmodule

// File: tb/tb_router_reg.sv
// Directed testbench for router_reg: drives FSM flag sequences cycle by
// cycle and compares dout/status against hand-computed values.
module tb_router_reg;
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_DET  = 6'b100000;
  localparam logic [5:0] F_LFD  = 6'b010000;
  localparam logic [5:0] F_LD   = 6'b001000;
  localparam logic [5:0] F_LAF  = 6'b000100;
  localparam logic [5:0] F_FULL = 6'b000010;
  localparam logic [5:0] F_RINT = 6'b000001;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  router_reg_if bus ();

  router_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic [5:0] fl, input logic pv, input logic [7:0] d,
                      input logic ff);
    {bus.detect_addr, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_int_req} = fl;
    bus.pkt_valid = pv;
    bus.data_in   = d;
    bus.fifo_full = ff;
    @(posedge clk);
    #1;
  endtask

  // Header + three payload bytes + parity byte, FIFO never full.
  task automatic run_packet(input string nm, input logic [7:0] hdr,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] par,
                            input logic exp_err);
    step(F_DET, 1'b1, hdr, 1'b0);
    check({nm, "_pd_clr"}, 8'(bus.parity_done), 8'h00);
    step(F_LFD, 1'b1, b0, 1'b0);
    check({nm, "_dout_hdr"}, bus.dout, hdr);
    step(F_LD, 1'b1, b0, 1'b0);
    check({nm, "_dout_b0"}, bus.dout, b0);
    step(F_LD, 1'b1, b1, 1'b0);
    check({nm, "_dout_b1"}, bus.dout, b1);
    step(F_LD, 1'b1, b2, 1'b0);
    check({nm, "_dout_b2"}, bus.dout, b2);
    check({nm, "_pd_early"}, 8'(bus.parity_done), 8'h00);
    step(F_LD, 1'b0, par, 1'b0);
    check({nm, "_dout_par"}, bus.dout, par);
    check({nm, "_pd_set"}, 8'(bus.parity_done), 8'h01);
    check({nm, "_err_early"}, 8'(bus.err), 8'h00);
    step(F_NONE, 1'b0, 8'h00, 1'b0);
    check({nm, "_err"}, 8'(bus.err), 8'(exp_err));
    step(F_RINT, 1'b0, 8'h00, 1'b0);
    check({nm, "_lpv_clr"}, 8'(bus.low_pkt_valid), 8'h00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    step(F_NONE, 1'b0, 8'h00, 1'b0);
    step(F_NONE, 1'b0, 8'h00, 1'b0);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_pd",   8'(bus.parity_done), 8'h00);
    check("rst_lpv",  8'(bus.low_pkt_valid), 8'h00);
    check("rst_err",  8'(bus.err), 8'h00);
    rst = 1'b1;

    run_packet("good", 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 1'b0);
    run_packet("bad",  8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF, 1'b1);
    check("bad_err_hold", 8'(bus.err), 8'h01);

    // detect_addr collides with a parity-done set condition: clears win.
    step(F_DET | F_LD, 1'b0, 8'h44, 1'b0);
    check("prio_pd",  8'(bus.parity_done), 8'h00);
    check("prio_err", 8'(bus.err), 8'h00);
    // rst_int_req collides with a low_pkt_valid set: clear wins.
    step(F_RINT | F_LD, 1'b0, 8'h00, 1'b1);
    check("prio_lpv", 8'(bus.low_pkt_valid), 8'h00);

    // FIFO full on the second payload byte.
    step(F_DET, 1'b1, 8'h0D, 1'b0);
    step(F_LFD, 1'b1, 8'h11, 1'b0);
    check("full_dout_hdr", bus.dout, 8'h0D);
    step(F_LD, 1'b1, 8'h11, 1'b0);
    check("full_dout_11", bus.dout, 8'h11);
    step(F_LD, 1'b1, 8'h22, 1'b1);
    check("full_dout_hold", bus.dout, 8'h11);
    step(F_FULL, 1'b1, 8'h22, 1'b1);
    check("full_dout_fs", bus.dout, 8'h11);
    step(F_LAF, 1'b1, 8'h33, 1'b0);
    check("full_dout_laf", bus.dout, 8'h22);
    check("full_pd_laf", 8'(bus.parity_done), 8'h00);
    step(F_LD, 1'b1, 8'h33, 1'b0);
    check("full_dout_33", bus.dout, 8'h33);
    step(F_LD, 1'b0, 8'h0D, 1'b0);
    check("full_pd", 8'(bus.parity_done), 8'h01);
    step(F_NONE, 1'b0, 8'h00, 1'b0);
    check("full_err", 8'(bus.err), 8'h00);
    step(F_RINT, 1'b0, 8'h00, 1'b0);

    // Packet ends while the FIFO is full: parity byte parked, done in laf.
    step(F_DET, 1'b1, 8'h05, 1'b0);
    step(F_LFD, 1'b1, 8'h11, 1'b0);
    check("lpv_dout_hdr", bus.dout, 8'h05);
    step(F_LD, 1'b1, 8'h11, 1'b0);
    step(F_LD, 1'b0, 8'h14, 1'b1);
    check("lpv_set", 8'(bus.low_pkt_valid), 8'h01);
    check("lpv_pd_hold", 8'(bus.parity_done), 8'h00);
    check("lpv_dout_hold", bus.dout, 8'h11);
    step(F_FULL, 1'b0, 8'h14, 1'b1);
    step(F_LAF, 1'b0, 8'h00, 1'b0);
    check("lpv_dout_laf", bus.dout, 8'h14);
    check("lpv_pd_laf", 8'(bus.parity_done), 8'h01);
    step(F_RINT, 1'b0, 8'h00, 1'b0);
    check("lpv_clr", 8'(bus.low_pkt_valid), 8'h00);

    // Address 3 header is ignored; previous header 05 is replayed.
    step(F_DET, 1'b1, 8'h0F, 1'b0);
    check("inv_err_clr", 8'(bus.err), 8'h00);
    step(F_LFD, 1'b1, 8'h00, 1'b0);
    check("inv_hdr", bus.dout, 8'h05);
    step(F_RINT, 1'b0, 8'h00, 1'b0);

    // Reset after two payload bytes, then a clean packet.
    step(F_DET, 1'b1, 8'h0D, 1'b0);
    step(F_LFD, 1'b1, 8'h11, 1'b0);
    step(F_LD, 1'b1, 8'h11, 1'b0);
    step(F_LD, 1'b1, 8'h22, 1'b0);
    check("mid_dout_pre", bus.dout, 8'h22);
    rst = 1'b0;
    step(F_NONE, 1'b0, 8'h00, 1'b0);
    check("mid_dout", bus.dout, 8'h00);
    check("mid_pd",   8'(bus.parity_done), 8'h00);
    check("mid_lpv",  8'(bus.low_pkt_valid), 8'h00);
    check("mid_err",  8'(bus.err), 8'h00);
    rst = 1'b1;
    step(F_NONE, 1'b0, 8'h00, 1'b0);
    check("mid_err_after", 8'(bus.err), 8'h00);
    check("mid_pd_after",  8'(bus.parity_done), 8'h00);
    run_packet("post", 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: pkt_valid  in  1  source byte valid; deasserted while the parity byte is on data_in.
REQ-004 SHALL have: data_in  in  8  source byte stream; header byte = {len[5:0], addr[1:0]}.
REQ-005 SHALL have: fifo_full  in  1  destination FIFO full.
REQ-006 SHALL have: detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_req  in  1 each  one-hot state flags from the router FSM.
REQ-007 SHALL have: dout  out  8  byte to destination FIFO.
REQ-008 SHALL have: parity_done  out  1  parity byte received.
REQ-009 SHALL have: low_pkt_valid  out  1  packet ended while loading.
REQ-010 SHALL have: err  out  1  parity mismatch.

Function
REQ-011 SHALL hold internal registers: header (8), full_byte (8), int_parity (8), pkt_parity (8).
REQ-012 SHALL capture header <= data_in when detect_addr && pkt_valid && data_in[1:0] != 2'b11; addr 3 ignored.
REQ-013 dout SHALL update, priority order: lfd_state -> header; ld_state && !fifo_full -> data_in; laf_state -> full_byte; otherwise hold.
REQ-014 SHALL capture full_byte <= data_in when ld_state && fifo_full; dout holds that cycle.
REQ-015 int_parity SHALL clear on detect_addr; lfd_state -> int_parity ^ header; ld_state && pkt_valid && !full_state -> int_parity ^ data_in; otherwise hold.
REQ-016 full_byte SHALL be folded into int_parity exactly once, at its ld_state capture; not again in laf_state.
REQ-017 SHALL capture pkt_parity <= data_in when ld_state && !pkt_valid && !fifo_full.
REQ-018 parity_done SHALL set when (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done).
REQ-019 parity_done SHALL clear on detect_addr; otherwise hold; set has priority over nothing else.
REQ-020 low_pkt_valid SHALL set when ld_state && !pkt_valid; SHALL clear when rst_int_req; clear wins if both.
REQ-021 err SHALL be evaluated one cycle after parity_done rises: err <= (int_parity != pkt_parity).
REQ-022 err SHALL hold until the next detect_addr, which clears it.
REQ-023 Latency: header/data byte appears on dout one clk after its qualifying state cycle.
REQ-024 Simultaneous flags (FSM fault): detect_addr clears take priority over all set conditions.

Reset
REQ-025 On rst=0 at a rising edge: dout, header, full_byte, int_parity, pkt_parity = 8'h00; parity_done, low_pkt_valid, err = 0.
REQ-026 Reset asserted mid-packet SHALL discard all packet state; no partial err or parity_done afterwards.

Verification
REQ-027 Normal packet: header 8'h0D, payload 8'h11,8'h22,8'h33, parity 8'h0D, fifo_full=0 -> dout sequence 0D,11,22,33,0D; parity_done=1 after parity byte; err=0.
REQ-028 Bad parity: same packet, parity byte 8'hFF -> parity_done=1, err=1 one clk later; err clears on next detect_addr.
REQ-029 FIFO full: fifo_full=1 during ld_state with data_in=8'h22 -> dout holds 8'h11; after full_state then laf_state dout=8'h22; final int_parity=8'h0D, err=0.
REQ-030 Packet ends during full: pkt_valid drops while full, low_pkt_valid=1; laf_state -> parity_done=1; rst_int_req -> low_pkt_valid=0.
REQ-031 Invalid address: detect_addr && pkt_valid, data_in=8'h0F -> header unchanged from prior value.
REQ-032 Reset mid-packet: rst=0 after two payload bytes -> all outputs 0 next clk; new 8'h0D packet then passes with err=0.
